// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the register index type.
package cpu_pkg;

    localparam int unsigned REG_W = 4;
    localparam int unsigned NREGS = 16;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = reg_idx_t'(0);

endpackage : cpu_pkg

// File: rtl/reg_scoreboard_if.sv
// Decode/execute <-> scoreboard signal bundle: issue request, retire, flush and status.
interface reg_scoreboard_if
    import cpu_pkg::*;
#(
    parameter int unsigned NREGS = cpu_pkg::NREGS
) ();

    logic             issue_valid;
    reg_idx_t         issue_src0;
    reg_idx_t         issue_src1;
    logic             issue_src0_en;
    logic             issue_src1_en;
    reg_idx_t         issue_dst;
    logic             issue_dst_en;
    logic             issue_ready;
    logic             retire_valid;
    reg_idx_t         retire_dst;
    logic             flush;
    logic [NREGS-1:0] busy;
    logic [7:0]       inflight;
    logic             err;

    // Pipeline side: drives issue/retire/flush, observes scoreboard status.
    modport master (
        output issue_valid, issue_src0, issue_src1, issue_src0_en, issue_src1_en,
        output issue_dst, issue_dst_en, retire_valid, retire_dst, flush,
        input  issue_ready, busy, inflight, err
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_src0, issue_src1, issue_src0_en, issue_src1_en,
        input  issue_dst, issue_dst_en, retire_valid, retire_dst, flush,
        output issue_ready, busy, inflight, err
    );

endinterface : reg_scoreboard_if

// File: rtl/sb_counter.sv
// Per-register in-flight counter: saturating up/down with synchronous clear.
module sb_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             nonzero_c,
    output logic             full_c,
    output logic             underflow_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign nonzero_c   = |cnt;
    assign full_c      = (cnt == CNT_MAX);
    // Simultaneous inc+dec cancel, so only a lone decrement of zero is an underflow.
    assign underflow_c = !clr && dec && !inc && !nonzero_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && !full_c) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && nonzero_c) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule : sb_counter

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: counts in-flight writers per register and gates issue.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned NREGS         = cpu_pkg::NREGS,
    parameter int unsigned CNT_W         = 3,
    parameter int unsigned RETIRE_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_scoreboard_if.slave  sb
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NREGS];
    logic [NREGS-1:0] nonzero;
    logic [NREGS-1:0] full;
    logic [NREGS-1:0] underflow;
    logic [NREGS-1:0] inc;
    logic [NREGS-1:0] dec;
    logic [NREGS-1:0] reg_free;

    logic dst_en_eff;
    logic src0_haz;
    logic src1_haz;
    logic dst_blk;
    logic ready_c;
    logic fire;
    logic err_q;
    logic [7:0] inflight_c;

    // r0 is hardwired: never counted, never a hazard.
    assign cnt[0]       = '0;
    assign nonzero[0]   = 1'b0;
    assign full[0]      = 1'b0;
    assign underflow[0] = 1'b0;
    assign inc[0]       = 1'b0;
    assign dec[0]       = 1'b0;
    assign reg_free[0]  = 1'b1;

    assign dst_en_eff = sb.issue_dst_en && (sb.issue_dst != ZERO_REG);
    assign fire       = sb.issue_valid && ready_c;

    for (genvar g = 1; g < NREGS; g++) begin : g_reg
        assign inc[g] = fire && dst_en_eff && (sb.issue_dst == REG_W'(g));
        assign dec[g] = sb.retire_valid && (sb.retire_dst == REG_W'(g));
        // A last writer retiring this cycle frees the register for a same-cycle reader.
        assign reg_free[g] = !nonzero[g] ||
                             ((RETIRE_BYPASS != 0) && dec[g] && (cnt[g] == CNT_ONE));

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .clr         (sb.flush),
            .inc         (inc[g]),
            .dec         (dec[g]),
            .cnt         (cnt[g]),
            .nonzero_c   (nonzero[g]),
            .full_c      (full[g]),
            .underflow_c (underflow[g])
        );
    end

    // Issue gating: operand hazards, full destination counter, flush.
    always_comb begin
        src0_haz = 1'b0;
        src1_haz = 1'b0;
        dst_blk  = 1'b0;
        src0_haz = sb.issue_src0_en && !reg_free[sb.issue_src0];
        src1_haz = sb.issue_src1_en && !reg_free[sb.issue_src1];
        dst_blk  = dst_en_eff && full[sb.issue_dst];
        ready_c  = !sb.flush && !src0_haz && !src1_haz && !dst_blk;
    end

    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < NREGS; i++) begin
            inflight_c = inflight_c + 8'(cnt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (|underflow) begin
            err_q <= 1'b1;
        end
    end

    assign sb.issue_ready = ready_c;
    assign sb.busy        = nonzero;
    assign sb.inflight    = inflight_c;
    assign sb.err         = err_q;

endmodule : reg_scoreboard
